// File: rtl/in_port_pkg.sv
// rtl/in_port_pkg.sv - shared types and helpers for the In port handshake
package in_port_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RELEASED,
        WAIT_PRESS,
        WAIT_RELEASE,
        DONE
    } in_state_t;

    localparam int DB_CYCLES_DEFAULT = 50000;
    localparam int DB_W              = $clog2(DB_CYCLES_DEFAULT + 1);

    // Widen the 16-bit switch bank to a register-file word.
    function automatic logic [31:0] extend(input logic [15:0] value, input logic sign_ext);
        return {{16{sign_ext & value[15]}}, value};
    endfunction

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - button synchroniser, polarity normalisation and debouncer
module button_debounce #(
    parameter logic [15:0] DB_CYCLES      = 16'd50000,
    parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
    input  logic clock,
    input  logic Reset,
    input  logic raw,
    output logic level
);

    localparam int              CNT_W = $clog2(int'(DB_CYCLES) + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 16'd1);
    localparam logic             REL  = BTN_ACTIVE_LOW;

    logic             sync_1;
    logic             sync_2;
    logic             btn_raw;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            sync_1 <= REL;
            sync_2 <= REL;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
        end
    end

    assign btn_raw = sync_2 ^ REL;

    // The level flips on the DB_CYCLES-th consecutive disagreeing sample.
    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (btn_raw == level) begin
            cnt <= '0;
        end else if (cnt >= LAST) begin
            cnt   <= '0;
            level <= btn_raw;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/in_port_handshake.sv
// rtl/in_port_handshake.sv - In instruction handshake: stall, press/release capture, write strobe
module in_port_handshake
    import in_port_pkg::*;
#(
    parameter logic [15:0] DB_CYCLES      = 16'd50000,
    parameter bit          BTN_ACTIVE_LOW = 1'b1,
    parameter bit          SIGN_EXT       = 1'b1
) (
    input  logic        clock,
    input  logic        Reset,
    input  logic        flag_In,
    input  logic [15:0] switches,
    input  logic        enterButton,
    output logic [31:0] data_In,
    output logic        data_Valid,
    output logic        stall_Out,
    output logic        waiting
);

    in_state_t state;
    in_state_t next_state;
    logic      btn_db;

    button_debounce #(
        .DB_CYCLES      (DB_CYCLES),
        .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
    ) u_debounce (
        .clock (clock),
        .Reset (Reset),
        .raw   (enterButton),
        .level (btn_db)
    );

    // A button already held when the request arrives must be released first.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:          if (flag_In) next_state = btn_db ? WAIT_RELEASED : WAIT_PRESS;
            WAIT_RELEASED: if (!btn_db) next_state = WAIT_PRESS;
            WAIT_PRESS:    if (btn_db)  next_state = WAIT_RELEASE;
            WAIT_RELEASE:  if (!btn_db) next_state = DONE;
            DONE:          next_state = IDLE;
            default:       next_state = IDLE;
        endcase
    end

    always_comb begin
        stall_Out  = 1'b0;
        data_Valid = 1'b0;
        case (state)
            IDLE:                                   stall_Out  = flag_In;
            WAIT_RELEASED, WAIT_PRESS, WAIT_RELEASE: stall_Out  = 1'b1;
            DONE:                                   data_Valid = 1'b1;
            default:                                stall_Out  = 1'b0;
        endcase
    end

    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            waiting <= 1'b0;
            data_In <= '0;
        end else begin
            state   <= next_state;
            waiting <= (next_state != IDLE) && (next_state != DONE);
            // WAIT_PRESS is only entered with btn_db low, so a high level here is the press edge.
            if (state == WAIT_PRESS && btn_db) begin
                data_In <= extend(switches, SIGN_EXT);
            end
        end
    end

endmodule

// File: tb/tb_in_port_handshake.sv
// tb/tb_in_port_handshake.sv - self-checking bench for in_port_handshake
module tb_in_port_handshake;

    logic        clock = 1'b0;
    logic        Reset;
    logic        flag_In;
    logic [15:0] switches;
    logic        enterButton;
    logic [31:0] data_In,    data_In_z;
    logic        data_Valid, data_Valid_z;
    logic        stall_Out,  stall_Out_z;
    logic        waiting,    waiting_z;

    int n_checks   = 0;
    int n_fail     = 0;
    int cycle      = 0;
    int pulses     = 0;
    int exp_pulses = 0;
    int pulse_cycle[$];
    logic [15:0] last_sw = 16'h0000;

    in_port_handshake #(.DB_CYCLES(16'd4), .BTN_ACTIVE_LOW(1'b1), .SIGN_EXT(1'b1)) dut (
        .clock(clock), .Reset(Reset), .flag_In(flag_In), .switches(switches),
        .enterButton(enterButton), .data_In(data_In), .data_Valid(data_Valid),
        .stall_Out(stall_Out), .waiting(waiting)
    );

    in_port_handshake #(.DB_CYCLES(16'd4), .BTN_ACTIVE_LOW(1'b1), .SIGN_EXT(1'b0)) dut_z (
        .clock(clock), .Reset(Reset), .flag_In(flag_In), .switches(switches),
        .enterButton(enterButton), .data_In(data_In_z), .data_Valid(data_Valid_z),
        .stall_Out(stall_Out_z), .waiting(waiting_z)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle++;

    always @(negedge clock) begin
        if (!Reset && data_Valid) begin
            pulses++;
            pulse_cycle.push_back(cycle);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_ext(input logic [15:0] sw, input bit sx);
        logic [31:0] r;
        r = 32'(sw);
        if (sx && sw >= 16'h8000) r = r + 32'hFFFF_0000;
        return r;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic press(input int n);
        enterButton = 1'b0;
        cyc(n);
    endtask

    task automatic release_btn(input int n);
        enterButton = 1'b1;
        cyc(n);
    endtask

    task automatic wait_valid(input logic [15:0] sw, input string tag);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clock);
            if (data_Valid) begin
                got = 1'b1;
                check({tag, "_data"},   data_In,      model_ext(sw, 1'b1));
                check({tag, "_data_z"}, data_In_z,    model_ext(sw, 1'b0));
                check({tag, "_stall"},  32'(stall_Out), 32'd0);
                check({tag, "_valid_z"}, 32'(data_Valid_z), 32'd1);
            end
        end
        if (!got) check({tag, "_timeout"}, 32'(data_Valid), 32'd1);
        exp_pulses++;
        last_sw = sw;
    endtask

    initial begin
        logic [15:0] sw;
        logic [15:0] sw2;
        int          diff;

        Reset = 1'b1; flag_In = 1'b0; switches = 16'h0000; enterButton = 1'b1;
        #1;
        check("rst_data",    data_In,             32'd0);
        check("rst_valid",   32'(data_Valid),     32'd0);
        check("rst_waiting", 32'(waiting),        32'd0);
        check("rst_stall",   32'(stall_Out),      32'd0);
        cyc(2);
        Reset = 1'b0;
        cyc(3);

        // Basic input
        switches = 16'h0005;
        flag_In  = 1'b1;
        #1;
        check("basic_stall_first", 32'(stall_Out), 32'd1);
        cyc(1);
        check("basic_waiting", 32'(waiting), 32'd1);
        press(10);
        check("basic_hold_stall", 32'(stall_Out), 32'd1);
        enterButton = 1'b1;
        wait_valid(16'h0005, "basic");
        flag_In = 1'b0;
        cyc(3);
        check("basic_pulses", pulses, exp_pulses);
        check("basic_idle_stall", 32'(stall_Out), 32'd0);
        check("basic_hold_data", data_In, 32'h0000_0005);

        // Sign extension
        switches = 16'hFFFE;
        flag_In  = 1'b1;
        cyc(1);
        press(10);
        enterButton = 1'b1;
        wait_valid(16'hFFFE, "sext");
        flag_In = 1'b0;
        cyc(3);

        // Pre-held button
        switches = 16'h1234;
        press(10);
        flag_In = 1'b1;
        #1;
        check("pre_stall", 32'(stall_Out), 32'd1);
        cyc(1);
        check("pre_waiting", 32'(waiting), 32'd1);
        cyc(8);
        check("pre_no_pulse", pulses, exp_pulses);
        check("pre_no_capture", data_In, model_ext(last_sw, 1'b1));
        release_btn(10);
        check("pre_rel_no_pulse", pulses, exp_pulses);
        check("pre_rel_stall", 32'(stall_Out), 32'd1);
        press(10);
        enterButton = 1'b1;
        wait_valid(16'h1234, "pre");
        flag_In = 1'b0;
        cyc(3);
        check("pre_pulses", pulses, exp_pulses);

        // Glitch rejection and switch change while held
        switches = 16'h0001;
        flag_In  = 1'b1;
        cyc(1);
        repeat (3) begin
            press(3);
            release_btn(2);
        end
        cyc(4);
        check("glitch_no_pulse",   pulses, exp_pulses);
        check("glitch_stall",      32'(stall_Out), 32'd1);
        check("glitch_no_capture", data_In, model_ext(last_sw, 1'b1));
        press(8);
        switches = 16'h0002;
        release_btn(2);
        press(4);
        check("glitch_blip_stall", 32'(stall_Out), 32'd1);
        check("glitch_blip_no_pulse", pulses, exp_pulses);
        enterButton = 1'b1;
        wait_valid(16'h0001, "glitch");
        flag_In = 1'b0;
        cyc(3);

        // Back-to-back In instructions
        switches = 16'h0007;
        flag_In  = 1'b1;
        cyc(1);
        press(10);
        enterButton = 1'b1;
        wait_valid(16'h0007, "b2b_a");
        switches = 16'h0009;
        cyc(2);
        check("b2b_restall",  32'(stall_Out), 32'd1);
        check("b2b_rewait",   32'(waiting),   32'd1);
        press(10);
        enterButton = 1'b1;
        wait_valid(16'h0009, "b2b_b");
        flag_In = 1'b0;
        cyc(3);
        check("b2b_pulses", pulses, exp_pulses);
        diff = (pulse_cycle.size() >= 2) ? pulse_cycle[$] - pulse_cycle[$-1] : 0;
        check("b2b_gap", 32'(diff >= 12), 32'd1);

        // Randomised requests with glitches, blips and late switch changes
        for (int t = 0; t < 6; t++) begin
            sw  = 16'($urandom);
            sw2 = 16'($urandom);
            switches = sw;
            flag_In  = 1'b1;
            cyc(1);
            repeat ($urandom_range(1, 3)) begin
                press($urandom_range(1, 3));
                release_btn($urandom_range(1, 3));
            end
            cyc(3);
            check("rnd_glitch_no_pulse", pulses, exp_pulses);
            check("rnd_glitch_stall",    32'(stall_Out), 32'd1);
            check("rnd_glitch_data",     data_In, model_ext(last_sw, 1'b1));
            press(8);
            switches = sw2;
            release_btn(2);
            press($urandom_range(2, 6));
            enterButton = 1'b1;
            wait_valid(sw, "rnd");
            flag_In = 1'b0;
            cyc(2);
            check("rnd_pulses", pulses, exp_pulses);
        end

        // Asynchronous reset while waiting for release
        switches = 16'h00AA;
        flag_In  = 1'b1;
        cyc(1);
        press(10);
        check("arst_pre_waiting", 32'(waiting), 32'd1);
        @(posedge clock);
        #3;
        Reset   = 1'b1;
        flag_In = 1'b0;
        #1;
        check("arst_data",    data_In,         32'd0);
        check("arst_data_z",  data_In_z,       32'd0);
        check("arst_valid",   32'(data_Valid), 32'd0);
        check("arst_waiting", 32'(waiting),    32'd0);
        check("arst_stall",   32'(stall_Out),  32'd0);
        cyc(1);
        Reset = 1'b0;
        release_btn(15);
        check("arst_no_pulse", pulses, exp_pulses);
        check("arst_data_after", data_In, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/in_port_handshake.md
Name: in_port_handshake

Overview:
Input-side peripheral for the single-cycle MIPS core, the reader counterpart of the Out display port. When the control unit decodes an In instruction, this block stalls the PC until the user sets the switches and presses and releases the Enter button. It then presents the captured, extended switch value to the register-bank write path for exactly one cycle. It also contains its own button synchroniser and debouncer.

Parameters:
DB_CYCLES, 16'd50000, number of consecutive clock cycles a raw button level must be stable before it is accepted; minimum 2.
BTN_ACTIVE_LOW, 1, 1 = raw button reads 0 when pressed (board KEY); 0 = active-high.
SIGN_EXT, 1, 1 = sign-extend switches[15] into data_In[31:16]; 0 = zero-extend.

Ports:
clock  input  1  system clock, the same clock as PC/RegisterBank; all state changes on its rising edge.
Reset  input  1  asynchronous, active-high; clears all state immediately.
flag_In  input  1  from ControlUnit; high while the current instruction is In.
switches  input  16  raw board switches, treated as quasi-static.
enterButton  input  1  raw, asynchronous Enter button.
data_In  output  32  captured extended switch value, to the write-data mux.
data_Valid  output  1  one-cycle strobe; the register bank may write data_In.
stall_Out  output  1  to ProgramCounter hold input; 1 = PC must not advance.
waiting  output  1  LED indication; high while user input is awaited.

Behaviour:
- Reset values: state IDLE, data_In = 0, data_Valid = 0, waiting = 0, synchroniser flops = released level, debounced level = released, debounce counter = 0.
- Button path:
  - 2-flop synchroniser, then polarity normalisation to btn_raw (1 = pressed).
  - The debounced level btn_db changes only after btn_raw has differed from btn_db for DB_CYCLES consecutive cycles.
  - The counter clears whenever btn_raw equals btn_db, and saturates; it never wraps.
  - Latency from a clean edge to a btn_db change is 2 + DB_CYCLES cycles.
- FSM states: IDLE, WAIT_RELEASED, WAIT_PRESS, WAIT_RELEASE, DONE.
  - IDLE: if flag_In=1, go to WAIT_PRESS when btn_db=0, else WAIT_RELEASED. A button held before the request is never taken as confirmation.
  - WAIT_RELEASED: go to WAIT_PRESS when btn_db=0.
  - WAIT_PRESS: on btn_db 0->1, capture switches into data_In (extended per SIGN_EXT) and go to WAIT_RELEASE.
  - WAIT_RELEASE: on btn_db=0, go to DONE. Switch changes in this state are ignored; the capture at the press edge is final.
  - DONE: data_Valid=1 for this single cycle and stall_Out=0, so the PC advances and the register bank writes. flag_In is ignored in DONE because it is the same instruction. Unconditional transition to IDLE.
- stall_Out is combinational:
  - 1 when (state==IDLE and flag_In==1) or state is WAIT_RELEASED, WAIT_PRESS or WAIT_RELEASE.
  - 0 in DONE, and in IDLE with flag_In==0.
  - This guarantees the PC holds in the very cycle the In instruction is fetched.
- waiting = registered (state != IDLE and state != DONE).
- data_In holds its last captured value between requests and is not cleared in IDLE.
- Back-to-back In instructions: DONE -> IDLE -> a new request one cycle later. The button must again be released, then pressed, then released.
- flag_In dropping mid-wait (e.g. external halt): the FSM completes anyway; the core is frozen, so no hazard arises.
- Reset mid-operation: immediate return to IDLE, stall_Out drops, and any partial capture is discarded (data_In = 0).
- Glitches shorter than DB_CYCLES cycles never change btn_db and never advance the FSM.

Decomposition:
- Package in_port_pkg: state enum (IDLE, WAIT_RELEASED, WAIT_PRESS, WAIT_RELEASE, DONE), constant DB_W = clog2(DB_CYCLES+1), and the extend function (16->32 sign/zero).
- Sub-module button_debounce: synchroniser, polarity normalisation and saturating counter. Ports: clock, Reset, raw, level. Parameters DB_CYCLES and BTN_ACTIVE_LOW.
- The FSM, capture register and stall logic stay in in_port_handshake.

Test Plan:
All scenarios use DB_CYCLES=4 and BTN_ACTIVE_LOW=1.
- Basic input: switches=16'h0005, flag_In=1, clean press of 10 cycles then release -> stall_Out=1 from the first flag_In cycle; data_Valid pulses once; data_In=32'h00000005; stall_Out=0 in that same cycle.
- Sign extension: switches=16'hFFFE with SIGN_EXT=1 -> data_In=32'hFFFFFFFE; with SIGN_EXT=0 -> 32'h0000FFFE.
- Pre-held button: button pressed before flag_In rises -> state WAIT_RELEASED, no capture; after release plus a new press/release -> a single data_Valid.
- Glitch rejection: 3-cycle press pulses and 2-cycle release blips -> no capture and stall_Out stays 1. A switch change from 16'h0001 to 16'h0002 during WAIT_RELEASE -> data_In=32'h00000001.
- Back-to-back In: two consecutive requests with 16'h0007 then 16'h0009 -> two separate data_Valid pulses at least 2*(2+4) cycles apart, with values 7 then 9.
- Async reset in WAIT_RELEASE -> outputs go to reset values within the same cycle without a clock edge; no data_Valid follows.
